// File: rtl/xillybus_mem8_pkg.sv
// Shared constants for the 8-bit Xillybus register window: address map, ID bytes
// and CTRL/STAT bit positions.
package xillybus_mem8_pkg;

  localparam logic [4:0] AddrId0     = 5'h00;
  localparam logic [4:0] AddrId1     = 5'h01;
  localparam logic [4:0] AddrId2     = 5'h02;
  localparam logic [4:0] AddrId3     = 5'h03;
  localparam logic [4:0] AddrLed     = 5'h04;
  localparam logic [4:0] AddrCtrl    = 5'h05;
  localparam logic [4:0] AddrStat    = 5'h06;
  localparam logic [4:0] AddrScratch = 5'h07;
  localparam logic [4:0] AddrW128B0  = 5'h08;
  localparam logic [4:0] AddrW128B1  = 5'h09;
  localparam logic [4:0] AddrW128B2  = 5'h0A;
  localparam logic [4:0] AddrW128B3  = 5'h0B;
  localparam logic [4:0] AddrR128B0  = 5'h0C;
  localparam logic [4:0] AddrR128B1  = 5'h0D;
  localparam logic [4:0] AddrR128B2  = 5'h0E;
  localparam logic [4:0] AddrR128B3  = 5'h0F;

  localparam logic [7:0] IdByte0 = 8'h58;
  localparam logic [7:0] IdByte1 = 8'h42;
  localparam logic [7:0] IdByte2 = 8'h31;
  localparam logic [7:0] IdByte3 = 8'h32;

  localparam int unsigned CtrlSoftRstBit = 0;
  localparam int unsigned CtrlFreezeBit  = 1;
  localparam int unsigned StatWOvfBit    = 0;
  localparam int unsigned StatRUnfBit    = 1;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = IdByte0;
      2'd1:    b = IdByte1;
      2'd2:    b = IdByte2;
      default: b = IdByte3;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/xillybus_mem8_snapcnt.sv
// 32-bit event counter with a 24-bit shadow of the upper bytes, captured when the
// low byte is read so a multi-byte read sees one coherent value.
module xillybus_mem8_snapcnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        freeze_i,
  input  logic        clr_i,
  input  logic        snap_i,
  output logic [7:0]  count_lo_o,
  output logic [23:0] shadow_o
);

  logic [31:0] count_q, count_d;
  logic [23:0] shadow_q;

  // Clear wins over a coincident increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !freeze_i) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      shadow_q <= '0;
    end else begin
      count_q <= count_d;
      if (snap_i) begin
        shadow_q <= count_q[31:8];
      end
    end
  end

  assign count_lo_o = count_q[7:0];
  assign shadow_o   = shadow_q;

endmodule

// File: rtl/xillybus_mem8_regs.sv
// Byte-wide register file behind the Xillybus mem_8 interface: ID, LED, control,
// sticky status, two snapshot counters and a 16-byte scratch RAM.
module xillybus_mem8_regs
  import xillybus_mem8_pkg::*;
(
  input  logic       bus_clk,
  input  logic       trn_reset_n,
  input  logic [4:0] user_mem_8_addr,
  input  logic       user_mem_8_addr_update,
  input  logic       user_r_mem_8_rden,
  input  logic       user_r_mem_8_open,
  output logic [7:0] user_r_mem_8_data,
  output logic       user_r_mem_8_empty,
  output logic       user_r_mem_8_eof,
  input  logic       user_w_mem_8_wren,
  input  logic [7:0] user_w_mem_8_data,
  input  logic       user_w_mem_8_open,
  output logic       user_w_mem_8_full,
  input  logic       w128_wren,
  input  logic       w128_full,
  input  logic       r128_rden,
  input  logic       r128_empty,
  output logic [3:0] GPIO_LED,
  output logic       soft_rst
);

  logic [3:0]  led_q, led_d;
  logic        freeze_q, freeze_d;
  logic [1:0]  stat_q, stat_d, stat_set, stat_clr;
  logic [7:0]  scratch_q, scratch_d;
  logic        soft_rst_q, soft_rst_d;
  logic [7:0]  rdata_q, rdata_d, reg_rd;
  logic        sel_ram_q;
  logic [7:0]  ram [16];
  logic [7:0]  ram_rdata_q;
  logic [7:0]  w_lo, r_lo;
  logic [23:0] w_sh, r_sh;
  logic        is_ram, wr_en, rd_en;
  logic        unused_inputs;

  assign unused_inputs = ^{user_mem_8_addr_update, user_r_mem_8_open, user_w_mem_8_open};

  assign is_ram = user_mem_8_addr[4];
  assign wr_en  = user_w_mem_8_wren;
  assign rd_en  = user_r_mem_8_rden;

  xillybus_mem8_snapcnt u_w128 (
    .clk_i      (bus_clk),
    .rst_ni     (trn_reset_n),
    .inc_i      (w128_wren),
    .freeze_i   (freeze_q),
    .clr_i      (wr_en && (user_mem_8_addr == AddrW128B0)),
    .snap_i     (rd_en && (user_mem_8_addr == AddrW128B0)),
    .count_lo_o (w_lo),
    .shadow_o   (w_sh)
  );

  xillybus_mem8_snapcnt u_r128 (
    .clk_i      (bus_clk),
    .rst_ni     (trn_reset_n),
    .inc_i      (r128_rden),
    .freeze_i   (freeze_q),
    .clr_i      (wr_en && (user_mem_8_addr == AddrR128B0)),
    .snap_i     (rd_en && (user_mem_8_addr == AddrR128B0)),
    .count_lo_o (r_lo),
    .shadow_o   (r_sh)
  );

  // Register read mux; always sees pre-write state of the current cycle.
  always_comb begin
    reg_rd = 8'h00;
    case (user_mem_8_addr)
      AddrId0, AddrId1, AddrId2, AddrId3: reg_rd = id_byte(user_mem_8_addr[1:0]);
      AddrLed:     reg_rd = {4'h0, led_q};
      AddrCtrl:    reg_rd[CtrlFreezeBit] = freeze_q;
      AddrStat:    reg_rd = {6'b0, stat_q};
      AddrScratch: reg_rd = scratch_q;
      AddrW128B0:  reg_rd = w_lo;
      AddrW128B1:  reg_rd = w_sh[7:0];
      AddrW128B2:  reg_rd = w_sh[15:8];
      AddrW128B3:  reg_rd = w_sh[23:16];
      AddrR128B0:  reg_rd = r_lo;
      AddrR128B1:  reg_rd = r_sh[7:0];
      AddrR128B2:  reg_rd = r_sh[15:8];
      AddrR128B3:  reg_rd = r_sh[23:16];
      default:     reg_rd = 8'h00;
    endcase
  end

  always_comb begin
    led_d      = led_q;
    freeze_d   = freeze_q;
    scratch_d  = scratch_q;
    soft_rst_d = 1'b0;
    rdata_d    = rdata_q;
    stat_clr   = 2'b00;
    stat_set   = 2'b00;
    stat_set[StatWOvfBit] = w128_wren && w128_full;
    stat_set[StatRUnfBit] = r128_rden && r128_empty;
    if (rd_en && !is_ram) begin
      rdata_d = reg_rd;
    end
    if (wr_en) begin
      case (user_mem_8_addr)
        AddrLed:     led_d = user_w_mem_8_data[3:0];
        AddrCtrl: begin
          freeze_d   = user_w_mem_8_data[CtrlFreezeBit];
          soft_rst_d = user_w_mem_8_data[CtrlSoftRstBit];
        end
        AddrStat:    stat_clr = user_w_mem_8_data[1:0];
        AddrScratch: scratch_d = user_w_mem_8_data;
        default: ;
      endcase
    end
    // A new event in the same cycle as its W1C keeps the bit set.
    stat_d = (stat_q & ~stat_clr) | stat_set;
  end

  always_ff @(posedge bus_clk or negedge trn_reset_n) begin
    if (!trn_reset_n) begin
      led_q      <= '0;
      freeze_q   <= 1'b0;
      stat_q     <= '0;
      scratch_q  <= '0;
      soft_rst_q <= 1'b0;
      rdata_q    <= '0;
      sel_ram_q  <= 1'b0;
    end else begin
      led_q      <= led_d;
      freeze_q   <= freeze_d;
      stat_q     <= stat_d;
      scratch_q  <= scratch_d;
      soft_rst_q <= soft_rst_d;
      rdata_q    <= rdata_d;
      if (rd_en) begin
        sel_ram_q <= is_ram;
      end
    end
  end

  // Scratch RAM: no reset so it maps onto distributed RAM with a registered read.
  always_ff @(posedge bus_clk) begin
    if (wr_en && is_ram) begin
      ram[user_mem_8_addr[3:0]] <= user_w_mem_8_data;
    end
    if (rd_en && is_ram) begin
      ram_rdata_q <= ram[user_mem_8_addr[3:0]];
    end
  end

  assign user_r_mem_8_data  = sel_ram_q ? ram_rdata_q : rdata_q;
  assign user_r_mem_8_empty = 1'b0;
  assign user_r_mem_8_eof   = 1'b0;
  assign user_w_mem_8_full  = 1'b0;
  assign GPIO_LED           = led_q;
  assign soft_rst           = soft_rst_q;

endmodule

// File: tb/tb_xillybus_mem8_regs.sv
// Bench for xillybus_mem8_regs: directed table, corner-case sequences and random
// traffic checked against a byte-level model of the register map.
module tb_xillybus_mem8_regs;

  logic       bus_clk = 1'b0;
  logic       trn_reset_n;
  logic [4:0] addr;
  logic       addr_update, rden, ropen, wren, wopen;
  logic [7:0] rdata, wdata;
  logic       empty, eof, full;
  logic       w128_wren, w128_full, r128_rden, r128_empty;
  logic [3:0] led;
  logic       soft_rst;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 bus_clk = ~bus_clk;

  xillybus_mem8_regs dut (
    .bus_clk                (bus_clk),
    .trn_reset_n            (trn_reset_n),
    .user_mem_8_addr        (addr),
    .user_mem_8_addr_update (addr_update),
    .user_r_mem_8_rden      (rden),
    .user_r_mem_8_open      (ropen),
    .user_r_mem_8_data      (rdata),
    .user_r_mem_8_empty     (empty),
    .user_r_mem_8_eof       (eof),
    .user_w_mem_8_wren      (wren),
    .user_w_mem_8_data      (wdata),
    .user_w_mem_8_open      (wopen),
    .user_w_mem_8_full      (full),
    .w128_wren              (w128_wren),
    .w128_full              (w128_full),
    .r128_rden              (r128_rden),
    .r128_empty             (r128_empty),
    .GPIO_LED               (led),
    .soft_rst               (soft_rst)
  );

  // Reference model: the register map as plain bytes and integers.
  logic [3:0]  m_led;
  logic        m_freeze;
  logic [1:0]  m_stat;
  logic [7:0]  m_scratch;
  logic [31:0] m_wcnt, m_rcnt;
  logic [23:0] m_wsh, m_rsh;
  logic [7:0]  m_ram [16];
  bit          m_ram_ok [16];
  logic [7:0]  m_rd;
  bit          m_rd_ok;
  bit          m_soft;

  task automatic model_reset();
    m_led = '0; m_freeze = 1'b0; m_stat = '0; m_scratch = '0;
    m_wcnt = '0; m_rcnt = '0; m_wsh = '0; m_rsh = '0;
    m_rd = '0; m_rd_ok = 1'b1; m_soft = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [4:0] a);
    logic [7:0] id [4];
    id[0] = 8'h58; id[1] = 8'h42; id[2] = 8'h31; id[3] = 8'h32;
    if (a >= 5'd16) return m_ram[a - 5'd16];
    if (a <= 5'd3)  return id[a[1:0]];
    case (a)
      5'd4:  return {4'h0, m_led};
      5'd5:  return {6'b0, m_freeze, 1'b0};
      5'd6:  return {6'b0, m_stat};
      5'd7:  return m_scratch;
      5'd8:  return m_wcnt[7:0];
      5'd9:  return m_wsh[7:0];
      5'd10: return m_wsh[15:8];
      5'd11: return m_wsh[23:16];
      5'd12: return m_rcnt[7:0];
      5'd13: return m_rsh[7:0];
      5'd14: return m_rsh[15:8];
      default: return m_rsh[23:16];
    endcase
  endfunction

  // One clock edge of the specified behaviour, using the inputs currently driven.
  task automatic model_step();
    bit wr_stat;
    if (rden) begin
      m_rd    = m_read(addr);
      m_rd_ok = (addr < 5'd16) || m_ram_ok[addr - 5'd16];
    end
    m_soft = wren && (addr == 5'd5) && wdata[0];
    if (rden && addr == 5'd8)  m_wsh = m_wcnt[31:8];
    if (rden && addr == 5'd12) m_rsh = m_rcnt[31:8];
    if (wren && addr == 5'd8) m_wcnt = 0;
    else if (w128_wren && !m_freeze) m_wcnt = m_wcnt + 1;
    if (wren && addr == 5'd12) m_rcnt = 0;
    else if (r128_rden && !m_freeze) m_rcnt = m_rcnt + 1;
    wr_stat = wren && (addr == 5'd6);
    m_stat[0] = (m_stat[0] && !(wr_stat && wdata[0])) || (w128_wren && w128_full);
    m_stat[1] = (m_stat[1] && !(wr_stat && wdata[1])) || (r128_rden && r128_empty);
    if (wren) begin
      if (addr >= 5'd16) begin
        m_ram[addr - 5'd16] = wdata;
        m_ram_ok[addr - 5'd16] = 1'b1;
      end else if (addr == 5'd4) m_led = wdata[3:0];
      else if (addr == 5'd5) m_freeze = wdata[1];
      else if (addr == 5'd7) m_scratch = wdata;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, clock once, then compare at the next falling edge.
  task automatic step(input bit rd, input bit wr, input logic [4:0] a, input logic [7:0] d,
                      input bit ww, input bit wf, input bit rr, input bit re);
    rden = rd; wren = wr; addr = a; wdata = d;
    w128_wren = ww; w128_full = wf; r128_rden = rr; r128_empty = re;
    @(posedge bus_clk);
    model_step();
    @(negedge bus_clk);
    if (m_rd_ok) check("model_rdata", 32'(rdata), 32'(m_rd));
    check("model_led", 32'(led), 32'(m_led));
    check("model_soft_rst", 32'(soft_rst), 32'(m_soft));
    check("const_flags", 32'({empty, eof, full}), 32'd0);
  endtask

  task automatic rd(input logic [4:0] a);
    step(1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit         rd;
    bit         wr;
    logic [4:0] a;
    logic [7:0] d;
    logic [7:0] exp_rd;
    logic [3:0] exp_led;
    bit         exp_soft;
  } vec_t;

  vec_t vecs [18];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 5'h00, 8'h00, 8'h58, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 5'h01, 8'h00, 8'h42, 4'h0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 5'h02, 8'h00, 8'h31, 4'h0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 5'h03, 8'h00, 8'h32, 4'h0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 5'h04, 8'hFF, 8'h32, 4'hF, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 5'h04, 8'h00, 8'h0F, 4'hF, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 5'h00, 8'hAA, 8'h0F, 4'hF, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 5'h00, 8'h00, 8'h58, 4'hF, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 5'h07, 8'h3C, 8'h58, 4'hF, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 5'h07, 8'h00, 8'h3C, 4'hF, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 5'h05, 8'h01, 8'h3C, 4'hF, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 5'h00, 8'h00, 8'h3C, 4'hF, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 5'h05, 8'h00, 8'h00, 4'hF, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 5'h05, 8'h02, 8'h00, 4'hF, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 5'h05, 8'h00, 8'h02, 4'hF, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 5'h05, 8'h00, 8'h02, 4'hF, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 5'h09, 8'hFF, 8'h02, 4'hF, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 5'h09, 8'h00, 8'h00, 4'hF, 1'b0};

    foreach (m_ram_ok[i]) m_ram_ok[i] = 1'b0;
    trn_reset_n = 1'b0;
    addr = '0; addr_update = 1'b0; rden = 1'b0; ropen = 1'b1; wren = 1'b0; wopen = 1'b1;
    wdata = '0; w128_wren = 1'b0; w128_full = 1'b0; r128_rden = 1'b0; r128_empty = 1'b0;
    model_reset();
    repeat (3) @(negedge bus_clk);
    check("reset_rdata", 32'(rdata), 32'h0);
    check("reset_led", 32'(led), 32'h0);
    check("reset_soft_rst", 32'(soft_rst), 32'h0);
    trn_reset_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, 1'b0, 1'b0, 1'b0, 1'b0);
      check("vec_rdata", 32'(rdata), 32'(vecs[i].exp_rd));
      check("vec_led", 32'(led), 32'(vecs[i].exp_led));
      check("vec_soft_rst", 32'(soft_rst), 32'(vecs[i].exp_soft));
    end

    // Counter wrap from all-ones.
    force dut.u_w128.count_q = 32'hFFFF_FFFF;
    #1 release dut.u_w128.count_q;
    m_wcnt = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd(5'(8 + i));
      check("wrap_byte", 32'(rdata), 32'h0);
    end

    // Snapshot coincident with an increment captures the pre-increment value.
    force dut.u_w128.count_q = 32'h1234_56FF;
    #1 release dut.u_w128.count_q;
    m_wcnt = 32'h1234_56FF;
    step(1'b1, 1'b0, 5'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("snap_b0", 32'(rdata), 32'hFF);
    rd(5'h09); check("snap_b1", 32'(rdata), 32'h56);
    rd(5'h0A); check("snap_b2", 32'(rdata), 32'h34);
    rd(5'h0B); check("snap_b3", 32'(rdata), 32'h12);
    rd(5'h08); check("post_inc_b0", 32'(rdata), 32'h00);

    // Freeze holds the counter.
    wr(5'h05, 8'h02);
    step(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    rd(5'h08); check("frozen_b0", 32'(rdata), 32'h00);
    wr(5'h05, 8'h00);

    // Clear coincident with increment yields zero.
    step(1'b0, 1'b1, 5'h08, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    rd(5'h08); check("clr_b0", 32'(rdata), 32'h00);
    rd(5'h09); check("clr_b1", 32'(rdata), 32'h00);

    // Sticky status with W1C racing a new event.
    step(1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    rd(5'h06); check("stat_set", 32'(rdata), 32'h01);
    step(1'b0, 1'b1, 5'h06, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    rd(5'h06); check("stat_race", 32'(rdata), 32'h01);
    wr(5'h06, 8'h01);
    rd(5'h06); check("stat_clr", 32'(rdata), 32'h00);
    step(1'b0, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    rd(5'h06); check("stat_r", 32'(rdata), 32'h02);
    wr(5'h06, 8'h02);

    // Scratch RAM read-during-write returns the old byte.
    wr(5'h13, 8'h5A);
    step(1'b1, 1'b1, 5'h13, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ram_rdw_old", 32'(rdata), 32'h5A);
    rd(5'h13); check("ram_new", 32'(rdata), 32'hA5);

    // Asynchronous reset in the middle of activity.
    rd(5'h04);
    wr(5'h05, 8'h01);
    rden = 1'b1; wren = 1'b1; addr = 5'h07; wdata = 8'h99; w128_wren = 1'b1;
    #1 trn_reset_n = 1'b0;
    #1;
    check("async_rst_rdata", 32'(rdata), 32'h0);
    check("async_rst_led", 32'(led), 32'h0);
    check("async_rst_soft", 32'(soft_rst), 32'h0);
    repeat (2) @(negedge bus_clk);
    model_reset();
    trn_reset_n = 1'b1;
    step(1'b0, 1'b1, 5'h07, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    rd(5'h07); check("post_rst_write", 32'(rdata), 32'h77);
    rd(5'h08); check("post_rst_cnt", 32'(rdata), 32'h00);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(4, 15)) : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a, 8'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xillybus_mem8_regs.md
XILLYBUS_MEM8_REGS -- requirements
Module: xillybus_mem8_regs

Interface
REQ-001 SHALL have ports: bus_clk  in  1  sole clock; all logic rising-edge.
REQ-002 SHALL have: trn_reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: user_mem_8_addr  in  5  byte address from core, valid with rden/wren; user_mem_8_addr_update  in  1  address-change strobe, unused.
REQ-004 SHALL have: user_r_mem_8_rden  in  1  read strobe; user_r_mem_8_open  in  1  read side open, unused.
REQ-005 SHALL have: user_r_mem_8_data  out  8  read data; user_r_mem_8_empty  out  1; user_r_mem_8_eof  out  1.
REQ-006 SHALL have: user_w_mem_8_wren  in  1  write strobe; user_w_mem_8_data  in  8  write data; user_w_mem_8_open  in  1  unused; user_w_mem_8_full  out  1.
REQ-007 SHALL have: w128_wren, w128_full, r128_rden, r128_empty  in  1 each  128-bit stream activity taps.
REQ-008 SHALL have: GPIO_LED  out  4  LED drive; soft_rst  out  1  one-cycle user reset pulse.

Function
REQ-009 Register map SHALL be: 0x00-0x03 ID, read-only, 0x58 0x42 0x31 0x32; 0x04 LED, RW bits[3:0], bits[7:4] read 0; 0x05 CTRL; 0x06 STAT; 0x07 scratch RW; 0x08-0x0B W128 count; 0x0C-0x0F R128 count; 0x10-0x1F 16-byte scratch RAM RW.
REQ-010 Read latency SHALL be one cycle: rden in cycle N with addr A -> data[A] on user_r_mem_8_data from cycle N+1, held until next rden.
REQ-011 user_r_mem_8_empty, user_r_mem_8_eof, user_w_mem_8_full SHALL be constant 0 out of reset.
REQ-012 Write SHALL take effect on the wren edge; a read in the same cycle at the same address SHALL return the pre-write value.
REQ-013 Writes to read-only bytes (0x00-0x03, 0x09-0x0B, 0x0D-0x0F) SHALL be ignored.
REQ-014 CTRL bit0 write-1 SHALL produce soft_rst high for exactly one cycle after the write edge; bit0 SHALL read 0; CTRL bit1 FREEZE RW SHALL halt both counters while 1.
REQ-015 STAT bit0 SHALL set sticky on w128_wren && w128_full; bit1 on r128_rden && r128_empty; write-1-to-clear; simultaneous set and clear SHALL leave bit set.
REQ-016 Each counter SHALL be 32 bits, increment by 1 per strobe cycle (w128_wren / r128_rden) unless frozen, wrap 0xFFFFFFFF -> 0.
REQ-017 Reading the counter's low byte (0x08/0x0C) SHALL return bits[7:0] and atomically snapshot bits[31:8] into a shadow; reading upper bytes SHALL return shadow bytes, LE.
REQ-018 Snapshot coincident with an increment SHALL capture the pre-increment value.
REQ-019 Any write to 0x08/0x0C SHALL clear that counter; clear coincident with increment SHALL yield 0.
REQ-020 Simultaneous rden and wren to different addresses SHALL both complete in the same cycle.

Reset
REQ-021 Reset assertion SHALL asynchronously clear: read data 0x00, LED 0, CTRL 0, STAT 0, scratch 0x07 = 0, counters and shadows 0, soft_rst 0.
REQ-022 Scratch RAM 0x10-0x1F SHALL NOT be reset, and reads of it before any write return unspecified data.
REQ-023 Reset deassertion mid-transaction SHALL drop any in-flight strobe; first strobe is honoured on the first clock edge after release.
REQ-024 soft_rst SHALL NOT reset this block.

Structure
REQ-025 Package xillybus_mem8_pkg SHALL hold the address constants, ID bytes, and CTRL/STAT bit positions.
REQ-026 Counter-plus-snapshot SHALL be sub-module xillybus_mem8_snapcnt, instantiated twice.
REQ-027 Scratch RAM SHALL be inferable as 16x8 distributed RAM with registered read.

Verification
REQ-028 Reset, then rden at 0x00..0x03 -> data 0x58,0x42,0x31,0x32 one cycle after each rden.
REQ-029 wren 0x04 data 0xFF, rden 0x04 -> GPIO_LED=0xF, read 0x0F; wren 0x05 data 0x01 -> soft_rst high exactly one cycle, reread 0x05 = 0x00.
REQ-030 Force W128 counter to 0xFFFFFFFF, one w128_wren -> read 0x08..0x0B = 0x00,0x00,0x00,0x00; pulse wren during snapshot read -> upper bytes match pre-increment value.
REQ-031 w128_wren with w128_full -> STAT=0x01; same-cycle W1C of 0x01 and new overflow -> STAT stays 0x01; later W1C -> 0x00.
REQ-032 wren 0x13 data 0xA5 with same-cycle rden 0x13 -> read returns old value, next rden returns 0xA5.
REQ-033 Assert trn_reset_n low mid-burst -> all outputs 0 asynchronously, before next edge.
